// File: rtl/alu_rs_if.sv
// alu_rs_if: shared micro-op types plus the dispatch / CDB / issue bundle of the ALU reservation station.
package tomasula_types;
  localparam int TAG_MAX = 8;
  typedef enum logic [1:0] {ARITH = 2'd0, IMM = 2'd1, MEM = 2'd2, BR = 2'd3} op_t;
  typedef struct packed {
    op_t               op;
    logic [31:0]       src1_data;
    logic [31:0]       src2_data;
    logic [2:0]        funct3;
    logic              funct7;
    logic [TAG_MAX-1:0] tag;
    logic              load;
  } alu_word;
endpackage

interface alu_rs_if #(parameter int TAG_W = 3);
  logic                   flush;
  logic                   disp_valid;
  tomasula_types::op_t    disp_op;
  logic [2:0]             disp_funct3;
  logic                   disp_funct7;
  logic [TAG_W-1:0]       disp_dest;
  logic                   disp_rdy1;
  logic [31:0]            disp_val1;
  logic [TAG_W-1:0]       disp_tag1;
  logic                   disp_rdy2;
  logic [31:0]            disp_val2;
  logic [TAG_W-1:0]       disp_tag2;
  logic                   rs_full;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [31:0]            cdb_data;
  logic                   alu_ready;
  tomasula_types::alu_word alu_word;
  modport master (
    output flush, disp_valid, disp_op, disp_funct3, disp_funct7, disp_dest,
           disp_rdy1, disp_val1, disp_tag1, disp_rdy2, disp_val2, disp_tag2,
           cdb_valid, cdb_tag, cdb_data, alu_ready,
    input  rs_full, alu_word
  );
  modport slave (
    input  flush, disp_valid, disp_op, disp_funct3, disp_funct7, disp_dest,
           disp_rdy1, disp_val1, disp_tag1, disp_rdy2, disp_val2, disp_tag2,
           cdb_valid, cdb_tag, cdb_data, alu_ready,
    output rs_full, alu_word
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: integer ALU reservation station; holds micro-ops until both operands arrive, snoops the CDB, issues lowest ready index.
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_rs_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int TM = tomasula_types::TAG_MAX;
  typedef struct packed {
    logic                valid;
    tomasula_types::op_t op;
    logic [2:0]          funct3;
    logic                funct7;
    logic [TAG_W-1:0]    dest;
    logic                rdy1;
    logic [31:0]         val1;
    logic [TAG_W-1:0]    tag1;
    logic                rdy2;
    logic [31:0]         val2;
    logic [TAG_W-1:0]    tag2;
  } ent_t;
  ent_t                    r_ent [DEPTH];
  tomasula_types::alu_word r_out;
  logic                    w_full, w_has_iss, w_iss, w_disp, w_fwd1, w_fwd2;
  logic [IW-1:0]           w_free, w_sel;
  ent_t                    w_new;
  always_comb begin
    w_full    = 1'b1;
    w_has_iss = 1'b0;
    w_free    = '0;
    w_sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_full = w_full & r_ent[i].valid;
      if (!r_ent[i].valid) w_free = IW'(i);
      if (r_ent[i].valid && r_ent[i].rdy1 && r_ent[i].rdy2) begin
        w_has_iss = 1'b1;
        w_sel     = IW'(i);
      end
    end
  end
  assign w_iss  = w_has_iss & bus.alu_ready;
  assign w_disp = bus.disp_valid & ~w_full;
  // A producer broadcasting in the dispatch cycle would otherwise be missed forever.
  assign w_fwd1 = bus.cdb_valid & ~bus.disp_rdy1 & (bus.disp_tag1 == bus.cdb_tag);
  assign w_fwd2 = bus.cdb_valid & ~bus.disp_rdy2 & (bus.disp_tag2 == bus.cdb_tag);
  assign w_new = '{
    valid:  1'b1,
    op:     bus.disp_op,
    funct3: bus.disp_funct3,
    funct7: bus.disp_funct7,
    dest:   bus.disp_dest,
    rdy1:   bus.disp_rdy1 | w_fwd1,
    val1:   w_fwd1 ? bus.cdb_data : bus.disp_val1,
    tag1:   bus.disp_tag1,
    rdy2:   bus.disp_rdy2 | w_fwd2,
    val2:   w_fwd2 ? bus.cdb_data : bus.disp_val2,
    tag2:   bus.disp_tag2
  };
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_out <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_out.load <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid && !r_ent[i].rdy1 && bus.cdb_valid && r_ent[i].tag1 == bus.cdb_tag) begin
          r_ent[i].rdy1 <= 1'b1;
          r_ent[i].val1 <= bus.cdb_data;
        end
        if (r_ent[i].valid && !r_ent[i].rdy2 && bus.cdb_valid && r_ent[i].tag2 == bus.cdb_tag) begin
          r_ent[i].rdy2 <= 1'b1;
          r_ent[i].val2 <= bus.cdb_data;
        end
        if (w_iss && w_sel == IW'(i)) r_ent[i].valid <= 1'b0;
        if (w_disp && w_free == IW'(i)) r_ent[i] <= w_new;
      end
      if (w_iss)
        r_out <= '{
          op:        r_ent[w_sel].op,
          src1_data: r_ent[w_sel].val1,
          src2_data: r_ent[w_sel].val2,
          funct3:    r_ent[w_sel].funct3,
          funct7:    r_ent[w_sel].funct7,
          tag:       TM'(r_ent[w_sel].dest),
          load:      1'b1
        };
      else
        r_out.load <= 1'b0;
    end
  end
  assign bus.rs_full  = w_full;
  assign bus.alu_word = r_out;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed table, corner sequences and random traffic checked against a slot-array model.
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_rs_if #(.TAG_W(3)) bus();
  alu_rs #(.DEPTH(4), .TAG_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errs = 0;
  int checks = 0;
  typedef struct {
    bit v; logic [1:0] op; logic [2:0] f3; bit f7; logic [7:0] dest;
    bit r1; logic [31:0] v1; logic [2:0] t1;
    bit r2; logic [31:0] v2; logic [2:0] t2;
  } m_ent_t;
  m_ent_t m [4];
  bit e_load;
  logic [1:0] e_op;
  logic [31:0] e_s1, e_s2;
  logic [2:0] e_f3;
  bit e_f7;
  logic [7:0] e_tag;
  typedef struct {
    bit dv; bit f7; int dest; bit r1; int v1; int t1; bit r2; int v2; int t2;
    bit cv; int ct; int cd;
    bit el; int es1; int es2; int etag; bit ef7;
  } vec_t;
  vec_t tbl [9];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = '{default: '0};
    e_load = 0;
  endtask
  task automatic set_disp(input bit dv, input bit f7, input int dest, input bit r1, input int v1,
                          input int t1, input bit r2, input int v2, input int t2);
    bus.disp_valid = dv; bus.disp_op = tomasula_types::ARITH; bus.disp_funct3 = 3'd0;
    bus.disp_funct7 = f7; bus.disp_dest = 3'(dest);
    bus.disp_rdy1 = r1; bus.disp_val1 = 32'(v1); bus.disp_tag1 = 3'(t1);
    bus.disp_rdy2 = r2; bus.disp_val2 = 32'(v2); bus.disp_tag2 = 3'(t2);
  endtask
  task automatic set_cdb(input bit cv, input int t, input int d);
    bus.cdb_valid = cv; bus.cdb_tag = 3'(t); bus.cdb_data = 32'(d);
  endtask
  // One clock: predict from the slot array, advance the edge, compare.
  task automatic tick();
    int sel = -1;
    int fr = -1;
    bit full = 1;
    bit exp_full = 1;
    for (int i = 0; i < 4; i++) begin
      full &= m[i].v;
      if (sel < 0 && m[i].v && m[i].r1 && m[i].r2) sel = i;
      if (fr < 0 && !m[i].v) fr = i;
    end
    if (bus.flush) begin
      for (int i = 0; i < 4; i++) m[i].v = 0;
      e_load = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (m[i].v && bus.cdb_valid) begin
        if (!m[i].r1 && m[i].t1 == bus.cdb_tag) begin m[i].r1 = 1; m[i].v1 = bus.cdb_data; end
        if (!m[i].r2 && m[i].t2 == bus.cdb_tag) begin m[i].r2 = 1; m[i].v2 = bus.cdb_data; end
      end
      if (sel >= 0 && bus.alu_ready) begin
        e_load = 1; e_op = m[sel].op; e_s1 = m[sel].v1; e_s2 = m[sel].v2;
        e_f3 = m[sel].f3; e_f7 = m[sel].f7; e_tag = m[sel].dest;
        m[sel].v = 0;
      end else e_load = 0;
      if (bus.disp_valid && !full) begin
        m[fr] = '{v: 1, op: bus.disp_op, f3: bus.disp_funct3, f7: bus.disp_funct7,
                  dest: 8'(bus.disp_dest), r1: bus.disp_rdy1, v1: bus.disp_val1, t1: bus.disp_tag1,
                  r2: bus.disp_rdy2, v2: bus.disp_val2, t2: bus.disp_tag2};
        if (!m[fr].r1 && bus.cdb_valid && m[fr].t1 == bus.cdb_tag) begin m[fr].r1 = 1; m[fr].v1 = bus.cdb_data; end
        if (!m[fr].r2 && bus.cdb_valid && m[fr].t2 == bus.cdb_tag) begin m[fr].r2 = 1; m[fr].v2 = bus.cdb_data; end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) exp_full &= m[i].v;
    check("model_load", 64'(bus.alu_word.load), 64'(e_load));
    check("model_full", 64'(bus.rs_full), 64'(exp_full));
    if (e_load) begin
      check("model_op", 64'(bus.alu_word.op), 64'(e_op));
      check("model_src1", 64'(bus.alu_word.src1_data), 64'(e_s1));
      check("model_src2", 64'(bus.alu_word.src2_data), 64'(e_s2));
      check("model_f3", 64'(bus.alu_word.funct3), 64'(e_f3));
      check("model_f7", 64'(bus.alu_word.funct7), 64'(e_f7));
      check("model_tag", 64'(bus.alu_word.tag), 64'(e_tag));
    end
  endtask
  task automatic idle();
    set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_cdb(0, 0, 0);
    bus.flush = 0;
  endtask
  initial begin
    tbl[0] = '{1, 0, 2, 1, 5, 0, 1, 7, 0,   0, 0, 0,   0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,   1, 5, 7, 2, 0};
    tbl[2] = '{1, 1, 5, 0, 0, 3, 1, 1, 0,   0, 0, 0,   0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4, 99,  0, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 10,  0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,   1, 10, 1, 5, 1};
    tbl[6] = '{1, 0, 6, 0, 0, 1, 1, 3, 0,   1, 1, 20,  0, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,   1, 20, 3, 6, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0};
    idle();
    bus.alu_ready = 1;
    model_reset();
    #12;
    check("reset_load", 64'(bus.alu_word.load), 64'd0);
    check("reset_word", 64'(bus.alu_word), 64'd0);
    check("reset_full", 64'(bus.rs_full), 64'd0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int r = 0; r < 9; r++) begin
      set_disp(tbl[r].dv, tbl[r].f7, tbl[r].dest, tbl[r].r1, tbl[r].v1, tbl[r].t1,
               tbl[r].r2, tbl[r].v2, tbl[r].t2);
      set_cdb(tbl[r].cv, tbl[r].ct, tbl[r].cd);
      tick();
      check($sformatf("tbl%0d_load", r), 64'(bus.alu_word.load), 64'(tbl[r].el));
      check($sformatf("tbl%0d_full", r), 64'(bus.rs_full), 64'd0);
      if (tbl[r].el) begin
        check($sformatf("tbl%0d_src1", r), 64'(bus.alu_word.src1_data), 64'(tbl[r].es1));
        check($sformatf("tbl%0d_src2", r), 64'(bus.alu_word.src2_data), 64'(tbl[r].es2));
        check($sformatf("tbl%0d_tag", r), 64'(bus.alu_word.tag), 64'(tbl[r].etag));
        check($sformatf("tbl%0d_f7", r), 64'(bus.alu_word.funct7), 64'(tbl[r].ef7));
      end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      set_disp(1, 0, i, 0, 0, 7, 1, i, 0);
      tick();
    end
    check("fill_full", 64'(bus.rs_full), 64'd1);
    set_disp(1, 0, 5, 1, 100, 0, 1, 100, 0);
    tick();
    check("fifth_ignored_full", 64'(bus.rs_full), 64'd1);
    check("fifth_no_load", 64'(bus.alu_word.load), 64'd0);
    idle();
    set_cdb(1, 7, 50);
    tick();
    set_cdb(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("order%0d_load", i), 64'(bus.alu_word.load), 64'd1);
      check($sformatf("order%0d_tag", i), 64'(bus.alu_word.tag), 64'(i));
      check($sformatf("order%0d_src1", i), 64'(bus.alu_word.src1_data), 64'd50);
      check($sformatf("order%0d_full", i), 64'(bus.rs_full), 64'd0);
    end
    tick();
    check("drained_load", 64'(bus.alu_word.load), 64'd0);
    bus.alu_ready = 0;
    set_disp(1, 0, 1, 1, 11, 0, 1, 12, 0); tick();
    set_disp(1, 0, 2, 1, 21, 0, 1, 22, 0); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_load", i), 64'(bus.alu_word.load), 64'd0);
    end
    bus.alu_ready = 1;
    tick();
    check("resume0_tag", 64'(bus.alu_word.tag), 64'd1);
    tick();
    check("resume1_tag", 64'(bus.alu_word.tag), 64'd2);
    check("resume1_load", 64'(bus.alu_word.load), 64'd1);
    bus.alu_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_disp(1, 0, i, 1, i, 0, 1, i, 0);
      tick();
    end
    idle();
    bus.alu_ready = 1;
    tick();
    check("preflush_load", 64'(bus.alu_word.load), 64'd1);
    bus.flush = 1;
    set_disp(1, 0, 7, 1, 77, 0, 1, 77, 0);
    tick();
    check("flush_load", 64'(bus.alu_word.load), 64'd0);
    check("flush_full", 64'(bus.rs_full), 64'd0);
    idle();
    tick();
    tick();
    check("postflush_empty", 64'(bus.alu_word.load), 64'd0);
    bus.alu_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_disp(1, 0, i, 1, 3, 0, 1, 4, 0);
      tick();
    end
    idle();
    check("prereset_full", 64'(bus.rs_full), 64'd1);
    #2 rst_n = 0;
    #1;
    check("async_reset_full", 64'(bus.rs_full), 64'd0);
    check("async_reset_load", 64'(bus.alu_word.load), 64'd0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    bus.alu_ready = 1;
    tick();
    check("postreset_load", 64'(bus.alu_word.load), 64'd0);
    for (int n = 0; n < 400; n++) begin
      bus.disp_valid  = ($urandom_range(0, 99) < 60);
      bus.disp_op     = tomasula_types::op_t'($urandom_range(0, 1));
      bus.disp_funct3 = 3'($urandom);
      bus.disp_funct7 = 1'($urandom);
      bus.disp_dest   = 3'($urandom);
      bus.disp_rdy1   = ($urandom_range(0, 99) < 50);
      bus.disp_val1   = $urandom;
      bus.disp_tag1   = 3'($urandom);
      bus.disp_rdy2   = ($urandom_range(0, 99) < 50);
      bus.disp_val2   = $urandom;
      bus.disp_tag2   = 3'($urandom);
      bus.cdb_valid   = ($urandom_range(0, 99) < 50);
      bus.cdb_tag     = 3'($urandom);
      bus.cdb_data    = $urandom;
      bus.alu_ready   = ($urandom_range(0, 99) < 75);
      bus.flush       = ($urandom_range(0, 49) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU in the Tomasulo back end. It accepts arithmetic and immediate micro-ops from dispatch and holds them until both operands are ready. While waiting, it snoops the common data bus (CDB) for pending operand tags. Each cycle it issues at most one ready entry to the combinational `alu` as a registered `alu_word`.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries (power of two, 2–16).
- `TAG_W`, default 3: ROB tag width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous squash of all entries and of the output register.
- Dispatch interface:
  - `disp_valid` in 1: dispatch request.
  - `disp_op` in `tomasula_types::op_t`: op class (ARITH or other).
  - `disp_funct3` in 3; `disp_funct7` in 1 (1 = sub/sra).
  - `disp_dest` in TAG_W: destination ROB tag.
  - `disp_rdy1` in 1; `disp_val1` in 32; `disp_tag1` in TAG_W: src1 ready flag, value, producer tag.
  - `disp_rdy2` in 1; `disp_val2` in 32; `disp_tag2` in TAG_W: same for src2.
  - `rs_full` out 1: all entries valid (combinational from registered state).
- CDB snoop:
  - `cdb_valid` in 1; `cdb_tag` in TAG_W; `cdb_data` in 32.
- ALU issue interface:
  - `alu_ready` in 1: downstream may accept an issue this cycle (CDB grant).
  - `alu_word` out `tomasula_types::alu_word`: registered. Fields: `op`, `src1_data`, `src2_data`, `funct3`, `funct7`, `tag`, `load` (issue valid).

## Operation
Per-entry state:
- `valid`, `op`, `funct3`, `funct7`, `dest`.
- Per operand: `rdy`, `val` (32), `tag`.

Dispatch:
- If `disp_valid && !rs_full && !flush`, write the lowest-index entry with `valid==0`.
- `disp_valid` while `rs_full` is ignored; upstream holds the request.

Dispatch-time forwarding:
- An operand with `disp_rdy==0` whose tag equals `cdb_tag` while `cdb_valid` is written ready, with `cdb_data`, in the same edge.

Snoop:
- Each valid entry with an operand `rdy==0` and `tag==cdb_tag` while `cdb_valid` captures `cdb_data` and sets `rdy`.
- Both operands of the same entry may capture in the same cycle.

Issue select:
- Combinational over registered state: the lowest-index entry with `valid && rdy1 && rdy2`.
- Operands captured this cycle are not eligible until next cycle.
- Selection is by index, not age.

Issue:
- If a candidate exists and `alu_ready`, the entry's fields load into the output register with `load=1`, and the entry's `valid` clears at the same edge.
- Otherwise the output register loads `load=0`. Data fields then hold their previous values (don't-care).

Simultaneous events:
- An entry freed by issue in cycle N is not reusable by dispatch until N+1, because `rs_full` uses registered `valid`.
- Dispatch into slot i and issue from slot j≠i in the same cycle are both performed.

Flush:
- Clears every `valid` and output `load` at the next edge.
- Has priority over dispatch, snoop and issue.

## Timing
- Reset: all `valid`=0, all `rdy`=0. `alu_word` is all zeros (`load`=0). `rs_full`=0.
- Latency, ready at dispatch: dispatched with both operands ready at edge N, the entry is eligible in cycle N; `alu_word.load`=1 after edge N+1.
- Latency, waiting on CDB: an operand tag broadcast in cycle M (captured at edge M+1) allows issue at the earliest at edge M+2.
- Throughput: one issue per cycle while `alu_ready` stays high and candidates exist.
- `alu_ready` low: no entry leaves; entries keep snooping.
- Reset asserted mid-operation: all state clears immediately (asynchronous).
- At `rs_full`, the dispatch handshake completes only when `!rs_full` at the sampling edge.

## Test plan
- Reset, then dispatch ADD with val1=5, val2=7 both ready, dest=2, `alu_ready`=1:
  - `alu_word.load`=1 two edges later, with src1=5, src2=7, tag=2.
  - Entry freed; `rs_full`=0.
- Dispatch SUB with src1 waiting on tag 3, src2=1, then drive the CDB with tag=3 data=10 one cycle later:
  - Issue appears 2 edges after the broadcast, with src1=10 and funct7=1.
  - A mismatched tag 4 broadcast causes no capture.
- Dispatch while the CDB broadcasts the same tag in that cycle:
  - The operand is captured ready (dispatch-time forwarding).
  - Issue follows on the next edge with the CDB data.
- Fill all 4 entries with operands not ready:
  - `rs_full`=1 and a 5th dispatch is ignored.
  - Broadcast the shared tag: entries issue one per cycle in index order 0,1,2,3.
  - `rs_full` drops the cycle after the first issue.
- Hold `alu_ready`=0 with 2 ready entries for 3 cycles:
  - `load`=0 throughout and no entry lost.
  - Raise `alu_ready`: issues on consecutive edges.
- Assert `flush` with 3 valid entries and `load`=1 pending:
  - Next edge gives all entries invalid, `load`=0, `rs_full`=0.
  - A dispatch in the flush cycle is dropped.
  - Also deassert `rst_n` mid-stream: immediate clear.
